// File: rtl/discus_dbg_pkg.sv
// -----------------------------------------------------------------------------
// discus_dbg_pkg
// Definitions shared by the discus debug path: the SPI command decoder and the
// CPU run controller.
//   - OP_* : 3-bit command opcodes carried on cmd_op
//   - dbg_state_e : run-controller state, also visible on the 'state' port
// -----------------------------------------------------------------------------
package discus_dbg_pkg;

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_HALT        = 3'd1;
  localparam logic [2:0] OP_RUN         = 3'd2;
  localparam logic [2:0] OP_STEP        = 3'd3;
  localparam logic [2:0] OP_SET_BP      = 3'd4;
  localparam logic [2:0] OP_CLR_BP      = 3'd5;
  localparam logic [2:0] OP_RESET_CPU   = 3'd6;
  localparam logic [2:0] OP_CLEAR_COUNT = 3'd7;

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_HALTED     = 2'd1,
    ST_RUNNING    = 2'd2,
    ST_STEPPING   = 2'd3
  } dbg_state_e;

  // An 8-bit step argument of zero stands for 256 steps.
  function automatic logic [8:0] step_count(input logic [7:0] arg);
    return (arg == 8'd0) ? 9'd256 : {1'b0, arg};
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones. A clear wins over an increment
// in the same cycle.
// Ports:
//   i_clk   : clock
//   i_rst   : asynchronous active-high reset (count -> 0)
//   i_clr   : synchronous clear
//   i_en    : count enable
//   o_count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_full;

  assign w_full  = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_full) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_run_ctrl
// Debug run controller for the discus CPU. Gates CPU execution through a
// clock-enable and sequences CPU reset, halt, free run and N-cycle stepping,
// with one PC breakpoint and a saturating count of enabled cycles.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   cmd_valid/ready   : command handshake (transfer when both high)
//   cmd_op, cmd_arg   : opcode (discus_dbg_pkg::OP_*) and 8-bit argument
//   fetch_PC          : PC the CPU fetches on its next enabled cycle
//   cpu_en            : CPU clock-enable (combinational)
//   cpu_reset         : reset to the CPU
//   halted            : state == HALTED
//   bp_hit            : sticky, set when the breakpoint stops execution
//   cycle_count       : saturating count of cpu_en cycles
//   state             : current dbg_state_e encoding
// -----------------------------------------------------------------------------
module cpu_run_ctrl
  import discus_dbg_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int PC_W         = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_arg,
  input  logic [PC_W-1:0]  fetch_PC,
  output logic             cpu_en,
  output logic             cpu_reset,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  localparam logic [7:0] HOLD_INIT = 8'(RESET_CYCLES);

  dbg_state_e      r_state;
  logic [7:0]      r_hold;
  logic [8:0]      r_step;
  logic            r_skip;
  logic            r_bp_valid;
  logic [PC_W-1:0] r_bp_addr;
  logic            r_bp_hit;

  logic w_cmd_ready;
  logic w_accept;
  logic w_active;
  logic w_bp_match;
  logic w_cpu_en;
  logic w_op_halt;
  logic w_op_run;
  logic w_op_step;
  logic w_op_set_bp;
  logic w_op_clr_bp;
  logic w_op_reset_cpu;
  logic w_op_clear_count;

  assign w_cmd_ready = (r_state != ST_RESET_HOLD);
  assign w_accept    = cmd_valid && w_cmd_ready;

  assign w_op_halt        = w_accept && (cmd_op == OP_HALT);
  assign w_op_run         = w_accept && (cmd_op == OP_RUN);
  assign w_op_step        = w_accept && (cmd_op == OP_STEP);
  assign w_op_set_bp      = w_accept && (cmd_op == OP_SET_BP);
  assign w_op_clr_bp      = w_accept && (cmd_op == OP_CLR_BP);
  assign w_op_reset_cpu   = w_accept && (cmd_op == OP_RESET_CPU);
  assign w_op_clear_count = w_accept && (cmd_op == OP_CLEAR_COUNT);

  assign w_active = (r_state == ST_RUNNING) || (r_state == ST_STEPPING);

  // The skip flag masks the breakpoint for the first enabled cycle after a
  // resume, so restarting from a breakpoint executes that instruction once.
  assign w_bp_match = r_bp_valid && (fetch_PC == r_bp_addr) && !r_skip;

  // The CPU is held off in the very cycle the breakpoint address is fetched,
  // so the instruction at bp_addr is not executed.
  assign w_cpu_en = w_active && !w_bp_match;

  assign cmd_ready = w_cmd_ready;
  assign cpu_en    = w_cpu_en;
  assign cpu_reset = (r_state == ST_RESET_HOLD);
  assign halted    = (r_state == ST_HALTED);
  assign bp_hit    = r_bp_hit;
  assign state     = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RESET_HOLD;
      r_hold     <= HOLD_INIT;
      r_step     <= '0;
      r_skip     <= 1'b0;
      r_bp_valid <= 1'b0;
      r_bp_addr  <= '0;
      r_bp_hit   <= 1'b0;
    end else begin
      // Breakpoint register updates land after this cycle's compare.
      if (w_op_set_bp) begin
        r_bp_addr  <= PC_W'(cmd_arg);
        r_bp_valid <= 1'b1;
      end else if (w_op_clr_bp) begin
        r_bp_valid <= 1'b0;
      end

      if (w_cpu_en) begin
        r_skip <= 1'b0;
      end

      if ((r_state == ST_STEPPING) && w_cpu_en) begin
        r_step <= r_step - 9'd1;
      end

      case (r_state)
        ST_RESET_HOLD: begin
          if (r_hold <= 8'd1) begin
            r_state <= ST_HALTED;
          end else begin
            r_hold <= r_hold - 8'd1;
          end
        end

        ST_HALTED: begin
          if (w_op_run) begin
            r_state  <= ST_RUNNING;
            r_bp_hit <= 1'b0;
            r_skip   <= 1'b1;
          end else if (w_op_step) begin
            r_state  <= ST_STEPPING;
            r_step   <= step_count(cmd_arg);
            r_bp_hit <= 1'b0;
            r_skip   <= 1'b1;
          end else if (w_op_reset_cpu) begin
            r_state <= ST_RESET_HOLD;
            r_hold  <= HOLD_INIT;
          end
        end

        ST_RUNNING, ST_STEPPING: begin
          // An accepted HALT or RESET_CPU decides the next state even when
          // the breakpoint matches; only HALT still records the hit.
          if (w_op_halt) begin
            r_state <= ST_HALTED;
            if (w_bp_match) begin
              r_bp_hit <= 1'b1;
            end
          end else if (w_op_reset_cpu) begin
            r_state <= ST_RESET_HOLD;
            r_hold  <= HOLD_INIT;
          end else if (w_bp_match) begin
            r_state  <= ST_HALTED;
            r_bp_hit <= 1'b1;
          end else if ((r_state == ST_STEPPING) && (r_step == 9'd1)) begin
            // Last step: cpu_en is high this cycle, halted from the next.
            r_state <= ST_HALTED;
          end
        end

        default: begin
          r_state <= ST_RESET_HOLD;
          r_hold  <= HOLD_INIT;
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_clr   (w_op_clear_count),
    .i_en    (w_cpu_en),
    .o_count (cycle_count)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  import discus_dbg_pkg::*;

  localparam int CW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [7:0]    cmd_arg = 8'd0;
  logic [7:0]    fetch_PC;
  logic [7:0]    pc_base = 8'd0;
  logic [7:0]    pc_cnt = 8'd0;
  logic          cmd_ready, cpu_en, cpu_reset, halted, bp_hit;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;

  typedef struct {
    string         name;
    logic [1:0]    st;
    logic          hit;
    logic [CW-1:0] cnt;
    int            en;
    int            rst;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  cpu_run_ctrl #(
    .RESET_CYCLES(4),
    .PC_W        (8),
    .CNT_W       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .fetch_PC   (fetch_PC),
    .cpu_en     (cpu_en),
    .cpu_reset  (cpu_reset),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .cycle_count(cycle_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Minimal CPU model: PC advances on every enabled clock edge.
  assign fetch_PC = pc_base + pc_cnt;
  always @(posedge clk) if (cpu_en) pc_cnt <= pc_cnt + 8'd1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] arg);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_base = v - pc_cnt;
  endtask

  task automatic expect_halt(input string nm, input logic hit, input int cnt,
                             input int en, input int rst);
    exp_t e;
    e.name = nm;
    e.st   = 2'd1;
    e.hit  = hit;
    e.cnt  = CW'(cnt);
    e.en   = en;
    e.rst  = rst;
    q.push_back(e);
  endtask

  task automatic wait_halt(input string nm, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (halted) return;
    end
    n_chk++;
    n_err++;
    $display("FAIL %s_timeout: halted still 0 after %0d cycles, required 1", nm, limit);
  endtask

  // Monitor: on every entry into HALTED, pop the expected record and compare.
  initial begin
    int   en_n;
    int   rst_n;
    logic prev;
    exp_t e;
    en_n = 0;
    rst_n = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        en_n = 0;
        rst_n = 0;
        prev = 1'b0;
      end else begin
        if (cpu_en) en_n++;
        if (cpu_reset) rst_n++;
        if (halted && !prev) begin
          if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_halt: entered HALTED with no expected event");
          end else begin
            e = q.pop_front();
            check({e.name, "_state"}, int'(state), int'(e.st));
            check({e.name, "_bp_hit"}, int'(bp_hit), int'(e.hit));
            check({e.name, "_count"}, int'(cycle_count), int'(e.cnt));
            check({e.name, "_en_cycles"}, en_n, e.en);
            if (e.rst >= 0) check({e.name, "_reset_cycles"}, rst_n, e.rst);
          end
          en_n = 0;
          rst_n = 0;
        end
        prev = halted;
      end
    end
  end

  initial begin
    // Reset values while reset is asserted
    #2 reset = 1'b1;
    #1;
    check("rst_state", int'(state), 0);
    check("rst_cpu_reset", int'(cpu_reset), 1);
    check("rst_cpu_en", int'(cpu_en), 0);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_bp_hit", int'(bp_hit), 0);
    check("rst_count", int'(cycle_count), 0);
    repeat (2) @(posedge clk);
    expect_halt("reset_release", 1'b0, 0, 0, 4);
    #1 reset = 1'b0;
    wait_halt("reset_release", 20);
    check("rel_cmd_ready", int'(cmd_ready), 1);
    check("rel_cpu_en", int'(cpu_en), 0);
    check("rel_cpu_reset", int'(cpu_reset), 0);

    // Stepping with breakpoint disabled
    expect_halt("step3", 1'b0, 3, 3, -1);
    send(OP_STEP, 8'd3);
    check("step3_state", int'(state), 3);
    wait_halt("step3", 20);
    expect_halt("step256", 1'b0, 259, 256, -1);
    send(OP_STEP, 8'd0);
    wait_halt("step256", 300);

    // Breakpoint at 0x10, run from 0x0C
    send(OP_SET_BP, 8'h10);
    send(OP_CLEAR_COUNT, 8'd0);
    check("clear_count", int'(cycle_count), 0);
    set_pc(8'h0C);
    expect_halt("bp_stop", 1'b1, 4, 4, -1);
    send(OP_RUN, 8'd0);
    wait_halt("bp_stop", 20);
    check("bp_stop_pc", int'(fetch_PC), 'h10);

    // Resume from breakpoint; RUN/STEP while running are ignored; HALT after 7
    expect_halt("run_halt", 1'b0, 11, 7, -1);
    send(OP_RUN, 8'd0);
    check("resume_bp_hit", int'(bp_hit), 0);
    check("resume_state", int'(state), 2);
    send(OP_RUN, 8'd0);
    check("run_in_run_state", int'(state), 2);
    check("run_in_run_ready", int'(cmd_ready), 1);
    send(OP_STEP, 8'd5);
    check("step_in_run_state", int'(state), 2);
    @(posedge clk);
    send(OP_HALT, 8'd0);
    check("halt_cpu_en", int'(cpu_en), 0);
    wait_halt("run_halt", 5);
    check("run_halt_pc", int'(fetch_PC), 'h17);

    // Breakpoint match and RESET_CPU in the same cycle
    set_pc(8'h0E);
    expect_halt("bp_reset", 1'b0, 13, 2, 4);
    send(OP_RUN, 8'd0);
    @(posedge clk);
    send(OP_RESET_CPU, 8'd0);
    check("bp_reset_state", int'(state), 0);
    check("bp_reset_bp_hit", int'(bp_hit), 0);
    check("bp_reset_cpu_reset", int'(cpu_reset), 1);
    check("bp_reset_ready", int'(cmd_ready), 0);
    check("bp_reset_count", int'(cycle_count), 13);
    wait_halt("bp_reset", 20);
    send(OP_CLEAR_COUNT, 8'd0);
    check("clear_after_reset", int'(cycle_count), 0);

    // Breakpoint survived RESET_CPU
    set_pc(8'h0E);
    expect_halt("bp_retained", 1'b1, 2, 2, -1);
    send(OP_RUN, 8'd0);
    wait_halt("bp_retained", 20);
    check("bp_retained_pc", int'(fetch_PC), 'h10);

    // CLR_BP: stepping through 0x10 no longer stops
    send(OP_CLR_BP, 8'd0);
    set_pc(8'h0E);
    expect_halt("clr_bp_step", 1'b0, 6, 4, -1);
    send(OP_STEP, 8'd4);
    wait_halt("clr_bp_step", 20);

    // Saturation: reach all-ones minus one, then run 5 more
    send(OP_CLEAR_COUNT, 8'd0);
    expect_halt("sat_256", 1'b0, 256, 256, -1);
    send(OP_STEP, 8'd0);
    wait_halt("sat_256", 300);
    expect_halt("sat_510", 1'b0, 510, 254, -1);
    send(OP_STEP, 8'd254);
    wait_halt("sat_510", 300);
    expect_halt("sat_hold", 1'b0, 511, 5, -1);
    send(OP_RUN, 8'd0);
    repeat (3) @(posedge clk);
    send(OP_HALT, 8'd0);
    wait_halt("sat_hold", 5);

    // Asynchronous reset in the middle of a STEP
    send(OP_STEP, 8'd100);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_state", int'(state), 0);
    check("mid_cpu_reset", int'(cpu_reset), 1);
    check("mid_cpu_en", int'(cpu_en), 0);
    check("mid_cmd_ready", int'(cmd_ready), 0);
    check("mid_count", int'(cycle_count), 0);
    check("mid_halted", int'(halted), 0);
    expect_halt("reset_mid_step", 1'b0, 0, 0, 4);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_halt("reset_mid_step", 20);

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_err += q.size();
      $display("FAIL pending_events: %0d expected halts never seen, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
